fwd_hazard_unit: RTL and testbench

Operand-forwarding and load-use hazard controller for the 5-stage PA-RISC pipeline. Tracks the destination register of every in-flight instruction in a shadow pipeline (EX, MEM, WB, RET slots). Drives the 2-bit selects of the two 32-bit 4:1 operand muxes in EX and the stall/bubble controls for IF/ID. Sits directly upstream of the EX operand muxes.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/fwd_select.sv | 26 ++
 rtl/fwd_hazard_unit.sv | 97 +++++++++
 tb/tb_fwd_hazard_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline slot types, forward-select encodings and register-file defaults
// for the forwarding / hazard logic.
package pipe_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned RW_DEF   = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_RET = 2'b11;

    typedef struct packed {
        logic              v;
        logic [RW_DEF-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    typedef struct packed {
        slot_t             s;
        logic [RW_DEF-1:0] rs1;
        logic [RW_DEF-1:0] rs2;
        logic              u1;
        logic              u2;
    } ex_slot_t;

    // True when the slot will write a nonzero register equal to r.
    function automatic logic writes(input slot_t s, input logic [RW_DEF-1:0] r);
        return s.v && s.we && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority compare of one EX source against the MEM/WB/RET slots; youngest writer wins.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [RW_DEF-1:0] rs,
    input  logic              used,
    input  slot_t             mem,
    input  slot_t             wb,
    input  slot_t             ret,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (used && rs != '0) begin
            // A load still in MEM has no data yet; the stall logic keeps this from happening.
            if (writes(mem, rs))
                sel = mem.ld ? FWD_RF : FWD_MEM;
            else if (writes(wb, rs))
                sel = FWD_WB;
            else if (writes(ret, rs))
                sel = FWD_RET;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow pipeline of in-flight destinations driving EX operand forwarding selects
// and the one-cycle load-use stall/bubble for IF/ID.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned RW   = RW_DEF,
    parameter int unsigned CW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [RW-1:0] id_rd,
    input  logic          id_rd_we,
    input  logic          id_is_load,
    input  logic          flush,
    output logic [1:0]    fwd_sel_a,
    output logic [1:0]    fwd_sel_b,
    output logic          stall,
    output logic          bubble,
    output logic [CW-1:0] stall_count
);

    ex_slot_t ex, ex_in;
    slot_t    mem, wb, ret;
    logic     ld_hit;

    always_comb begin
        ex_in       = '0;
        ex_in.s.v   = 1'b1;
        ex_in.s.rd  = id_rd;
        ex_in.s.we  = id_rd_we;
        ex_in.s.ld  = id_is_load;
        ex_in.rs1   = id_rs1;
        ex_in.rs2   = id_rs2;
        ex_in.u1    = id_rs1_used;
        ex_in.u2    = id_rs2_used;
    end

    always_comb begin
        ld_hit = ex.s.v && ex.s.ld && ex.s.we && (ex.s.rd != '0)
              && ((id_rs1_used && id_rs1 == ex.s.rd) || (id_rs2_used && id_rs2 == ex.s.rd));
        stall  = id_valid && !flush && ld_hit;
    end

    assign bubble = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex          <= '0;
            mem         <= '0;
            wb          <= '0;
            ret         <= '0;
            stall_count <= '0;
        end else begin
            ret <= wb;
            wb  <= mem;
            mem <= ex.s;
            if (id_valid && !stall && !flush)
                ex <= ex_in;
            else
                ex <= '0;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    fwd_select u_sel_a (
        .rs   (ex.rs1),
        .used (ex.u1),
        .mem  (mem),
        .wb   (wb),
        .ret  (ret),
        .sel  (fwd_sel_a)
    );

    fwd_select u_sel_b (
        .rs   (ex.rs2),
        .used (ex.u2),
        .mem  (mem),
        .wb   (wb),
        .ret  (ret),
        .sel  (fwd_sel_b)
    );

    // A MEM-stage load feeding an EX source means the load-use stall was bypassed.
    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !((ex.u1 && writes(mem, ex.rs1) && mem.ld) || (ex.u2 && writes(mem, ex.rs2) && mem.ld)));

    a_rd_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        !(id_valid && id_rd_we) || (32'(id_rd) < NREG));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance plus a CW=4 instance for saturation.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, flush;

    logic [1:0]  sel_a, sel_b, sel_a4, sel_b4;
    logic        stall, bubble, stall4, bubble4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
        .fwd_sel_a(sel_a), .fwd_sel_b(sel_b), .stall(stall), .bubble(bubble), .stall_count(cnt)
    );

    fwd_hazard_unit #(.CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
        .fwd_sel_a(sel_a4), .fwd_sel_b(sel_b4), .stall(stall4), .bubble(bubble4), .stall_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task set_id(input logic v, input logic [4:0] r1, input logic a1, input logic [4:0] r2,
                input logic a2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = a1; id_rs2 = r2; id_rs2_used = a2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task drain;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        repeat (4) tick();
    endtask

    task test_reset;
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++; if ({sel_a, sel_b, stall, bubble} !== 6'b0) begin n_bad++; $display("FAIL reset_outs: got %b want 000000", {sel_a, sel_b, stall, bubble}); end
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_cmp++; if ({sel_a4, sel_b4, stall4, bubble4, cnt4} !== 10'b0) begin n_bad++; $display("FAIL reset_outs4: got %b want 0", {sel_a4, sel_b4, stall4, bubble4, cnt4}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task test_alu_chain;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);               // ADD r3
        tick();
        set_id(1, 5'd3, 1, 0, 0, 5'd4, 1, 0);            // SUB reads r3
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_nostall: got %b want 0", stall); end
        tick();
        n_cmp++; if (sel_a !== 2'b01) begin n_bad++; $display("FAIL alu_mem sel_a: got %b want 01", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL alu_mem sel_b: got %b want 00", sel_b); end
        set_id(1, 5'd3, 1, 0, 0, 5'd6, 1, 0);
        tick();
        n_cmp++; if (sel_a !== 2'b10) begin n_bad++; $display("FAIL alu_wb sel_a: got %b want 10", sel_a); end
        set_id(1, 0, 0, 5'd3, 1, 5'd8, 1, 0);
        tick();
        n_cmp++; if (sel_b !== 2'b11) begin n_bad++; $display("FAIL alu_ret sel_b: got %b want 11", sel_b); end
        n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL alu_ret sel_a: got %b want 00", sel_a); end
        set_id(1, 5'd3, 1, 0, 0, 5'd9, 0, 0);
        tick();
        n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL alu_gone sel_a: got %b want 00", sel_a); end
    endtask

    task test_load_use;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 1);               // LDW r5
        tick();
        set_id(1, 0, 0, 5'd5, 1, 5'd10, 1, 0);           // consumer reads r5 on rs2
        #1;
        n_cmp++; if ({stall, bubble} !== 2'b11) begin n_bad++; $display("FAIL lu_stall: got %b want 11", {stall, bubble}); end
        tick();
        exp_cnt++;
        n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL lu_bubble sel_b: got %b want 00", sel_b); end
        n_cmp++; if ({stall, bubble} !== 2'b00) begin n_bad++; $display("FAIL lu_one_cycle: got %b want 00", {stall, bubble}); end
        tick();
        n_cmp++; if (sel_b !== 2'b10) begin n_bad++; $display("FAIL lu_wb sel_b: got %b want 10", sel_b); end
        n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL lu_cnt: got %0d want %0d", cnt, exp_cnt); end
    endtask

    task test_back_to_back;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 1);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd10, 1, 0);        // both sources hit the same load
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL dual_stall: got %b want 1", stall); end
        tick();
        exp_cnt++;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL dual_once: got %b want 0", stall); end
        tick();
        n_cmp++; if ({sel_a, sel_b} !== 4'b1010) begin n_bad++; $display("FAIL dual_sel: got %b want 1010", {sel_a, sel_b}); end
        n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL dual_cnt: got %0d want %0d", cnt, exp_cnt); end
    endtask

    task test_r0_unused;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd0, 1, 1);               // load to r0
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if ({sel_a, sel_b} !== 4'b0000) begin n_bad++; $display("FAIL r0_sel: got %b want 0000", {sel_a, sel_b}); end
        set_id(1, 0, 0, 0, 0, 5'd11, 1, 1);              // load r11
        tick();
        set_id(1, 5'd11, 0, 5'd11, 0, 5'd12, 1, 0);      // matches but unused
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL unused_stall: got %b want 0", stall); end
        tick();
        set_id(1, 5'd12, 0, 5'd12, 0, 0, 0, 0);          // ALU r12 in MEM, unused readers
        tick();
        n_cmp++; if ({sel_a, sel_b} !== 4'b0000) begin n_bad++; $display("FAIL unused_sel: got %b want 0000", {sel_a, sel_b}); end
    endtask

    task test_priority_flush;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 0);
        tick();
        set_id(1, 5'd7, 1, 0, 0, 5'd15, 1, 0);
        tick();
        n_cmp++; if (sel_a !== 2'b01) begin n_bad++; $display("FAIL prio_sel_a: got %b want 01", sel_a); end
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);               // LDW r7
        tick();
        set_id(1, 5'd7, 1, 0, 0, 5'd14, 1, 0);
        flush = 1'b1;
        #1;
        n_cmp++; if ({stall, bubble} !== 2'b00) begin n_bad++; $display("FAIL flush_stall: got %b want 00", {stall, bubble}); end
        tick();
        flush = 1'b0;
        set_id(1, 5'd14, 1, 0, 0, 0, 0, 0);              // would forward from a leaked r14 writer
        tick();
        n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL flush_bubble sel_a: got %b want 00", sel_a); end
        n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL flush_cnt: got %0d want %0d", cnt, exp_cnt); end
    endtask

    task test_saturation;
        int exp4;
        drain();
        for (int k = 0; k < 20; k++) begin
            set_id(1, 0, 0, 0, 0, 5'd5, 1, 1);
            tick();
            set_id(1, 5'd5, 1, 0, 0, 0, 0, 0);
            #1;
            n_cmp++; if (stall4 !== 1'b1) begin n_bad++; $display("FAIL sat_stall[%0d]: got %b want 1", k, stall4); end
            tick();
            exp_cnt++;
            exp4 = (exp_cnt > 15) ? 15 : exp_cnt;
            n_cmp++; if (cnt4 !== 4'(exp4)) begin n_bad++; $display("FAIL sat_cnt4[%0d]: got %0d want %0d", k, cnt4, exp4); end
        end
        n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt16: got %0d want %0d", cnt, exp_cnt); end
    endtask

    task test_async_reset;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);               // ADD r3
        tick();
        set_id(1, 5'd3, 1, 0, 0, 5'd5, 1, 1);            // LDW r5 reading r3
        tick();
        set_id(1, 0, 0, 5'd5, 1, 5'd6, 1, 0);
        #1;
        n_cmp++; if ({sel_a, stall} !== 3'b011) begin n_bad++; $display("FAIL pre_reset: got %b want 011", {sel_a, stall}); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sel_a, sel_b, stall, bubble} !== 6'b0) begin n_bad++; $display("FAIL async_outs: got %b want 000000", {sel_a, sel_b, stall, bubble}); end
        n_cmp++; if (cnt !== 16'd0 || cnt4 !== 4'd0) begin n_bad++; $display("FAIL async_cnt: got %0d/%0d want 0/0", cnt, cnt4); end
        @(negedge clk);
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_back_to_back();
        test_r0_unused();
        test_priority_flush();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
